// File: rtl/lsu.sv
// lsu: RV32I load/store unit sitting between EX and the data-memory bus.
// Runs one data-memory transaction at a time over a req/gnt/rvalid bus.
// It returns either a lane-extracted, sign- or zero-extended load result
// or a store completion. Illegal encodings and bus timeouts complete with
// an error pulse.
// Optional feature: define LSU_MISALIGN_TRAP_EN to turn misaligned
// halfword/word accesses into error completions with no bus access.
// Without it, the misaligned low address bits are ignored.
//
// Handshakes:
//   - EX side: a request transfers on the rising edge where
//     lsu_valid_i & lsu_ready_o. lsu_ready_o is high only in IDLE.
//     Every accepted request yields exactly one single-cycle lsu_rvalid_o.
//     lsu_err_o qualifies that pulse.
//   - Bus side: dmem_req_o stays high, with dmem_we_o/addr/be/wdata
//     stable, until the edge where dmem_gnt_i is sampled high. The
//     response is the first dmem_rvalid_i seen in WAIT. A dmem_rvalid_i
//     seen in IDLE or REQ is ignored.
module lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rvalid_o,
  output logic        lsu_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [1:0]  lsu_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;

  // Captured request
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  // Timeout counter and completion registers
  logic [15:0] cnt_q;
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  // Combinational decode
  logic        accept;
  logic        illegal;
  logic        misal;
  logic        req_err;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_fmt;
  logic        timeout_hit;
  logic        done_ok;
  logic        done_err;

  assign accept = lsu_valid_i & (state_q == S_IDLE);

  // The counter reaches TIMEOUT_CYC at the end of this cycle.
  assign timeout_hit = ((17'(cnt_q) + 17'd1) == 17'(TIMEOUT_CYC));

  // Classify the incoming request: illegal funct3 and optional misalignment.
  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    if (lsu_we_i) begin
      illegal = lsu_funct3_i[2] | (lsu_funct3_i[1:0] == 2'b11);
    end else begin
      illegal = (lsu_funct3_i == 3'b011) | (lsu_funct3_i[2:1] == 2'b11);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    case (lsu_funct3_i[1:0])
      2'b01:   misal = lsu_addr_i[0];
      2'b10:   misal = |lsu_addr_i[1:0];
      default: misal = 1'b0;
    endcase
`else
    misal = 1'b0;
`endif
    req_err = illegal | misal;
  end

  // Byte enables and lane-replicated write data. Loads read the full word.
  always_comb begin
    fmt_be    = 4'b1111;
    fmt_wdata = 32'h0;
    if (lsu_we_i) begin
      case (lsu_funct3_i[1:0])
        2'b00: begin
          fmt_be    = 4'b0001 << lsu_addr_i[1:0];
          fmt_wdata = {4{lsu_wdata_i[7:0]}};
        end
        2'b01: begin
          fmt_be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
          fmt_wdata = {2{lsu_wdata_i[15:0]}};
        end
        default: begin
          fmt_be    = 4'b1111;
          fmt_wdata = lsu_wdata_i;
        end
      endcase
    end
  end

  // Extract the addressed lane from the read word and extend it.
  always_comb begin
    lane_b   = 8'h00;
    lane_h   = 16'h0000;
    load_fmt = 32'h0;
    case (off_q)
      2'd0:    lane_b = dmem_rdata_i[7:0];
      2'd1:    lane_b = dmem_rdata_i[15:8];
      2'd2:    lane_b = dmem_rdata_i[23:16];
      default: lane_b = dmem_rdata_i[31:24];
    endcase
    lane_h = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_fmt = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_fmt = {24'h0, lane_b};
      3'b101:  load_fmt = {16'h0, lane_h};
      default: load_fmt = dmem_rdata_i;
    endcase
  end

  // Next state and completion decode.
  // In REQ a timeout beats a grant. In WAIT a response beats a timeout.
  always_comb begin
    state_d  = state_q;
    done_ok  = 1'b0;
    done_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            done_err = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (timeout_hit) begin
          state_d  = S_IDLE;
          done_err = 1'b1;
        end else if (dmem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = S_IDLE;
          done_ok = 1'b1;
        end else if (timeout_hit) begin
          state_d  = S_IDLE;
          done_err = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timeout counter: cleared on accept, counts every cycle spent in REQ/WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 16'd0;
    end else if (accept) begin
      cnt_q <= 16'd0;
    end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Capture a legal request. Bus-facing fields stay stable until the next accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= 32'h0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
    end else if (accept && !req_err) begin
      we_q    <= lsu_we_i;
      f3_q    <= lsu_funct3_i;
      off_q   <= lsu_addr_i[1:0];
      addr_q  <= {lsu_addr_i[31:2], 2'b00};
      be_q    <= fmt_be;
      wdata_q <= fmt_wdata;
    end
  end

  // Completion pulse and result. Stores and errors return zero.
  // The result holds until the next completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rvalid_q <= done_ok | done_err;
      err_q    <= done_err;
      if (done_err) begin
        rdata_q <= 32'h0;
      end else if (done_ok) begin
        rdata_q <= we_q ? 32'h0 : load_fmt;
      end
    end
  end

  assign lsu_ready_o  = (state_q == S_IDLE);
  assign lsu_rvalid_o = rvalid_q;
  assign lsu_err_o    = err_q;
  assign lsu_rdata_o  = rdata_q;
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign lsu_state_o  = state_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a behavioural model.
// The model is the completion queue, the ready/req windows and the
// formatting functions. A negedge compare process checks them every cycle.
module tb_lsu;

  localparam int T     = 4;
  localparam int NEVER = 1000;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        lsu_valid_i = 1'b0;
  logic        lsu_ready_o;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_funct3_i = 3'b000;
  logic [31:0] lsu_addr_i = 32'h0;
  logic [31:0] lsu_wdata_i = 32'h0;
  logic [31:0] lsu_rdata_o;
  logic        lsu_rvalid_o;
  logic        lsu_err_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'h0;
  logic [1:0]  state_dbg;

  lsu #(.TIMEOUT_CYC(T)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_we_i(lsu_we_i), .lsu_funct3_i(lsu_funct3_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_err_o(lsu_err_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .lsu_state_o(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [64:0] exp_q[$];   // {pulse cycle[31:0], err, rdata[31:0]}
  int busy_lo = 1, busy_hi = 0;
  int req_lo = 1, req_hi = 0;
  logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
  logic [3:0]  exp_be = 4'h0;
  logic        exp_we = 1'b0;
  logic [31:0] seen_addr = 32'h0, seen_wdata = 32'h0;
  logic [3:0]  seen_be = 4'h0;
  logic        seen_we = 1'b0;
  int last_pulse = 0, n_pulse = 0, req_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3 > 3'd2;
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic is_misal(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'd1) return a[0];
    if (f3[1:0] == 2'd2) return a[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'd0) return 4'(4'h1 << off);
    if (f3 == 3'd1) return 4'(4'h3 << (2 * off[1]));
    return 4'hF;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
    if (f3 == 3'd0) return (w & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [64:0] rec;
  logic        exp_req;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(lsu_ready_o), 32'(!(cyc >= busy_lo && cyc <= busy_hi)));
      exp_req = (cyc >= req_lo) && (cyc <= req_hi);
      chk("req", 32'(dmem_req_o), 32'(exp_req));
      if (dmem_req_o) begin
        req_cnt++;
        seen_addr = dmem_addr_o; seen_be = dmem_be_o;
        seen_we = dmem_we_o; seen_wdata = dmem_wdata_o;
        if (exp_req) begin
          chk("bus_addr", dmem_addr_o, exp_addr);
          chk("bus_be", 32'(dmem_be_o), 32'(exp_be));
          chk("bus_we", 32'(dmem_we_o), 32'(exp_we));
          if (exp_we) chk("bus_wdata", dmem_wdata_o, exp_wdata);
        end
      end
      if (lsu_rvalid_o) begin
        n_pulse++;
        last_pulse = cyc;
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_pulse: got rvalid=1 expected rvalid=0 (cycle %0d)", cyc);
        end else begin
          rec = exp_q.pop_front();
          chk("pulse_cycle", 32'(cyc), rec[64:33]);
          chk("pulse_err", 32'(lsu_err_o), 32'(rec[32]));
          chk("pulse_rdata", lsu_rdata_o, rec[31:0]);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][64:33]) <= cyc) begin
        rec = exp_q.pop_front();
        n_chk++; n_err++;
        $display("FAIL missed_pulse: got rvalid=0 expected rvalid=1 (cycle %0d)", cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called while the DUT is idle. Returns just after the negedge of the
  // completion cycle, with the DUT idle again.
  // gd: grant stall cycles; rd: response stall cycles after grant.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gd, input int rd,
                        input logic [31:0] word);
    int acc, pulse;
    logic e, tmo;
    acc = cyc;
    e   = is_illegal(we, f3) || (TRAP && is_misal(f3, addr));
    tmo = 1'b0;
    if (e) begin
      pulse = acc + 1;
      req_lo = 1; req_hi = 0;
    end else begin
      tmo = (gd + rd + 2) > T;
      pulse = tmo ? acc + T + 1 : acc + 3 + gd + rd;
      req_lo = acc + 1;
      req_hi = acc + ((gd + 1 < T) ? gd + 1 : T);
      exp_addr = addr & 32'hFFFF_FFFC;
      exp_we = we;
      exp_be = we ? store_be(f3, addr[1:0]) : 4'hF;
      exp_wdata = store_data(f3, wdata);
    end
    busy_lo = acc + 1; busy_hi = pulse - 1;
    exp_q.push_back({32'(pulse), e | tmo, (e | tmo | we) ? 32'h0 : load_val(f3, addr[1:0], word)});
    lsu_valid_i = 1'b1; lsu_we_i = we; lsu_funct3_i = f3;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    @(posedge clk); #1;
    lsu_valid_i = 1'b0;
    lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
    for (int c = acc + 1; c < pulse; c++) begin
      dmem_gnt_i = (c == acc + 1 + gd);
      dmem_rvalid_i = (c == acc + 2 + gd + rd);
      dmem_rdata_i = dmem_rvalid_i ? word : $urandom;
      @(posedge clk); #1;
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(lsu_ready_o), 32'd1);
    chk({tag, "_rvalid"}, 32'(lsu_rvalid_o), 32'd0);
    chk({tag, "_err"}, 32'(lsu_err_o), 32'd0);
    chk({tag, "_rdata"}, lsu_rdata_o, 32'h0);
    chk({tag, "_req"}, 32'(dmem_req_o), 32'd0);
    chk({tag, "_we"}, 32'(dmem_we_o), 32'd0);
    chk({tag, "_addr"}, dmem_addr_o, 32'h0);
    chk({tag, "_be"}, 32'(dmem_be_o), 32'd0);
    chk({tag, "_wdata"}, dmem_wdata_o, 32'h0);
    chk({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int a0, p0;
  initial begin
    #2 rst_ni = 1'b0;
    #1 chk_reset_outputs("rst");
    idle(2);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // LW, best case
    a0 = cyc;
    do_txn(1'b0, 3'b010, 32'h1000, 32'h0, 0, 0, 32'hDEADBEEF);
    chk("lw_rdata", lsu_rdata_o, 32'hDEADBEEF);
    chk("lw_addr", seen_addr, 32'h1000);
    chk("lw_be", 32'(seen_be), 32'hF);
    chk("lw_latency", 32'(last_pulse - a0), 32'd3);

    // Byte/half extraction and extension
    do_txn(1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80FF7F01);
    chk("lb_rdata", lsu_rdata_o, 32'hFFFFFF80);
    do_txn(1'b0, 3'b100, 32'h1003, 32'h0, 0, 0, 32'h80FF7F01);
    chk("lbu_rdata", lsu_rdata_o, 32'h00000080);
    do_txn(1'b0, 3'b001, 32'h1002, 32'h0, 0, 0, 32'h80FF7F01);
    chk("lh_rdata", lsu_rdata_o, 32'hFFFF80FF);
    do_txn(1'b0, 3'b101, 32'h1000, 32'h0, 0, 0, 32'h80FF7F01);
    chk("lhu_rdata", lsu_rdata_o, 32'h00007F01);
    do_txn(1'b0, 3'b000, 32'h1001, 32'h0, 0, 0, 32'h80FF7F01);
    chk("lb1_rdata", lsu_rdata_o, 32'h0000007F);

    // Stores
    do_txn(1'b1, 3'b001, 32'h2002, 32'h0000ABCD, 0, 0, 32'h0);
    chk("sh_be", 32'(seen_be), 32'hC);
    chk("sh_wdata", seen_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(seen_we), 32'd1);
    chk("sh_rdata", lsu_rdata_o, 32'h0);
    do_txn(1'b1, 3'b000, 32'h2001, 32'h12345678, 0, 0, 32'h0);
    chk("sb_be", 32'(seen_be), 32'h2);
    chk("sb_wdata", seen_wdata, 32'h78787878);
    do_txn(1'b1, 3'b010, 32'h2000, 32'hCAFEF00D, 0, 0, 32'h0);
    chk("sw_be", 32'(seen_be), 32'hF);
    chk("sw_wdata", seen_wdata, 32'hCAFEF00D);

    // Stalls add one cycle each
    a0 = cyc;
    do_txn(1'b0, 3'b010, 32'h1004, 32'h0, 1, 0, 32'h01234567);
    chk("gnt_stall_latency", 32'(last_pulse - a0), 32'd4);
    a0 = cyc;
    do_txn(1'b0, 3'b010, 32'h1008, 32'h0, 0, 1, 32'h89ABCDEF);
    chk("rsp_stall_latency", 32'(last_pulse - a0), 32'd4);
    chk("rsp_stall_rdata", lsu_rdata_o, 32'h89ABCDEF);

    // Illegal funct3, back to back, followed by a legal load
    a0 = cyc;
    do_txn(1'b0, 3'b011, 32'h3000, 32'h0, 0, 0, 32'h0);
    chk("ill_ld_latency", 32'(last_pulse - a0), 32'd1);
    chk("ill_ld_err", 32'(lsu_err_o), 32'd1);
    chk("ill_ld_rdata", lsu_rdata_o, 32'h0);
    do_txn(1'b1, 3'b011, 32'h3000, 32'h5555AAAA, 0, 0, 32'h0);
    do_txn(1'b0, 3'b111, 32'h3000, 32'h0, 0, 0, 32'h0);
    do_txn(1'b1, 3'b100, 32'h3000, 32'h0, 0, 0, 32'h0);
    do_txn(1'b0, 3'b110, 32'h3000, 32'h0, 0, 0, 32'h0);
    do_txn(1'b0, 3'b010, 32'h100C, 32'h0, 0, 0, 32'h0BADF00D);
    chk("after_err_rdata", lsu_rdata_o, 32'h0BADF00D);

    // Misaligned accesses
    a0 = cyc;
    do_txn(1'b0, 3'b010, 32'h1001, 32'h0, 0, 0, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lw_latency", 32'(last_pulse - a0), 32'd1);
    chk("mis_lw_rdata", lsu_rdata_o, 32'h0);
`else
    chk("mis_lw_addr", seen_addr, 32'h1000);
    chk("mis_lw_rdata", lsu_rdata_o, 32'h11223344);
`endif
    do_txn(1'b0, 3'b001, 32'h1003, 32'h0, 0, 0, 32'hAABBCCDD);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lh_err", 32'(lsu_err_o), 32'd1);
`else
    chk("mis_lh_rdata", lsu_rdata_o, 32'hFFFFAABB);
`endif
    do_txn(1'b1, 3'b010, 32'h2003, 32'h76543210, 0, 0, 32'h0);

    // Timeout in REQ, then a spurious response in IDLE
    a0 = cyc; req_cnt = 0;
    do_txn(1'b0, 3'b010, 32'h5000, 32'h0, NEVER, NEVER, 32'h0);
    chk("tmo_req_cycles", 32'(req_cnt), 32'd4);
    chk("tmo_latency", 32'(last_pulse - a0), 32'd5);
    chk("tmo_err", 32'(lsu_err_o), 32'd1);
    p0 = n_pulse;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
    idle(2);
    dmem_rvalid_i = 1'b0;
    idle(2);
    chk("spurious_pulses", 32'(n_pulse - p0), 32'd0);

    // Timeout in WAIT
    a0 = cyc;
    do_txn(1'b0, 3'b010, 32'h5004, 32'h0, 0, NEVER, 32'h0);
    chk("tmo_wait_latency", 32'(last_pulse - a0), 32'd5);

    // Mixed short transactions
    for (int i = 0; i < 10; i++) begin
      logic w;
      logic [2:0] f;
      int g;
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      g = int'($urandom_range(0, 1));
      do_txn(w, f, 32'h4000 + $urandom_range(0, 15), $urandom, g, 1 - g, $urandom);
    end

    // Reset while in WAIT
    do_txn(1'b0, 3'b010, 32'h1010, 32'h0, 0, 0, 32'h13579BDF);
    a0 = cyc;
    lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_funct3_i = 3'b010; lsu_addr_i = 32'h1000;
    req_lo = a0 + 1; req_hi = a0 + 1; busy_lo = a0 + 1; busy_hi = a0 + 100;
    exp_addr = 32'h1000; exp_be = 4'hF; exp_we = 1'b0;
    @(posedge clk); #1;
    lsu_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    @(negedge clk); #1;
    rst_ni = 1'b0;
    busy_lo = 1; busy_hi = 0; req_lo = 1; req_hi = 0;
    #1 chk_reset_outputs("midrst");
    idle(2);
    rst_ni = 1'b1;
    idle(2);
    chk("post_rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
    do_txn(1'b0, 3'b010, 32'h1000, 32'h0, 0, 0, 32'h5A5AA5A5);
    chk("post_rst_rdata", lsu_rdata_o, 32'h5A5AA5A5);
    chk("post_rst_err", 32'(lsu_err_o), 32'd0);

    idle(3);
    if (exp_q.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL leftover_completions: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the EX→MEM stage of the RV32I core. Takes the effective address computed by the ALU (its `alu_data_o`) plus `rs2` data and the load/store `funct3`. Runs one data-memory transaction at a time over a req/gnt/rvalid bus. Returns a formatted (lane-extracted, sign- or zero-extended) load result or a store completion, with misalignment and bus-timeout error reporting.

## Interface
- `TIMEOUT_CYC`, default 255: cycles allowed in REQ+WAIT before abort; range 1..65535.
- `clk_i` in 1: clock; all state changes on rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `lsu_valid_i` in 1: request valid from EX.
- `lsu_ready_o` out 1: 1 only in IDLE; request is accepted when `lsu_valid_i & lsu_ready_o`.
- `lsu_we_i` in 1: 1 = store, 0 = load.
- `lsu_funct3_i` in 3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `lsu_addr_i` in 32: byte address from ALU.
- `lsu_wdata_i` in 32: store data (`rs2`).
- `lsu_rdata_o` out 32: formatted load data; 0 for stores and errors.
- `lsu_rvalid_o` out 1: one-cycle completion pulse, for every accepted request.
- `lsu_err_o` out 1: asserted with `lsu_rvalid_o` on an error completion.
- `dmem_req_o` out 1: bus request.
- `dmem_we_o` out 1: bus write enable.
- `dmem_addr_o` out 32: word-aligned address, `[1:0]`=00.
- `dmem_be_o` out 4: byte enables.
- `dmem_wdata_o` out 32: lane-replicated store data.
- `dmem_gnt_i` in 1: grant.
- `dmem_rvalid_i` in 1: response valid; no earlier than the cycle after grant.
- `dmem_rdata_i` in 32: read word.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: on accept, capture `we`, `funct3`, `addr[1:0]`, word address, and formatted wdata/be. Go to REQ, or to IDLE with an error pulse (see errors).
- REQ: `dmem_req_o`=1 and all `dmem_*` outputs stable until `dmem_gnt_i`=1. Then go to WAIT; `dmem_req_o` drops next cycle.
- WAIT: on `dmem_rvalid_i`, register the formatted result, pulse `lsu_rvalid_o`, and go to IDLE. Stores also wait for rvalid.
- Store formatting:
  - SB: `be = 4'b0001 << addr[1:0]`, wdata = byte ×4.
  - SH: `be = 4'b0011 << {addr[1],1'b0}`, wdata = half ×2.
  - SW: `be = 4'b1111`.
- Loads: `be = 4'b1111`. Extract byte lane `addr[1:0]` or half lane `addr[1]`. LB/LH sign-extend; LBU/LHU zero-extend.
- Errors: no bus access, IDLE→IDLE, `lsu_rvalid_o=lsu_err_o=1` the next cycle, `lsu_rdata_o`=0. Triggers:
  - illegal funct3 (loads 011/110/111, stores ≥011), always checked;
  - misaligned access, only when the misalignment check is compiled in (see Configuration).
- Timeout: a counter clears on accept and increments each cycle in REQ/WAIT. On reaching `TIMEOUT_CYC`:
  - drop `dmem_req_o`;
  - go to IDLE;
  - pulse `lsu_rvalid_o` and `lsu_err_o`.
- `dmem_rvalid_i` seen in IDLE or REQ is ignored, e.g. a late response after a timeout.
- Reset (any time, including mid-transaction): state=IDLE, counter=0. All outputs reset to 0 except `lsu_ready_o`, which reads 1 once in IDLE. No pulse is emitted for an aborted transaction.

## Timing
- All outputs are registered or decoded from the state register; no combinational path from `dmem_*_i` to `dmem_*_o`.
- Best-case load/store, accepted in cycle 0:
  - `dmem_req_o`=1 in cycle 1, `gnt` in cycle 1;
  - `rvalid` in cycle 2;
  - `lsu_rvalid_o` and `lsu_rdata_o` in cycle 3, with `lsu_ready_o`=1 in cycle 3.
  - Throughput: one transaction per 3 cycles.
- Each grant stall or response stall adds one cycle.
- Error completion: pulse in cycle 1; next accept possible in cycle 1.
- `lsu_rdata_o` holds its value until the next completion.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: these are errors with no bus access:
  - LH/LHU/SH with `addr[0]`=1;
  - LW/SW with `addr[1:0]`≠00.
- Undefined: the misaligned low bits are ignored. Halfword uses `addr[1]` only; word uses lane 0. The access proceeds normally; `lsu_err_o` fires only for illegal funct3 or timeout.

## Test plan
- LW `0x1000`, bus returns `0xDEADBEEF` with gnt cycle 1, rvalid cycle 2 → `dmem_addr_o=0x1000`, `be=1111`; `lsu_rdata_o=0xDEADBEEF`, rvalid pulse in cycle 3.
- LB / LBU at `0x1003`, read word `0x80FF7F01` → LB gives `0xFFFFFF80`, LBU gives `0x00000080`.
- SH `0x2002`, wdata `0x0000ABCD` → `be=1100`, `dmem_wdata_o=0xABCDABCD`, `dmem_we_o=1`; completes with `err`=0.
- LW `0x1001`:
  - with `LSU_MISALIGN_TRAP_EN`: no `dmem_req_o`, err+rvalid in cycle 1, rdata 0;
  - without: bus sees `0x1000`, normal completion.
- `TIMEOUT_CYC=4`, gnt never asserted → `dmem_req_o` high 4 cycles then low; err+rvalid pulse; a later spurious `dmem_rvalid_i` in IDLE produces no pulse.
- `rst_ni` low while in WAIT, then released → all outputs 0, `lsu_ready_o`=1, no completion pulse; a following LW completes normally.
